// File: rtl/updown_bounded_counter.sv
// Bounded up/down counter: programmable lo/hi bounds, variable step,
// clamped load, saturate or wrap at bounds, status flags and event pulses.
// Ports: clk, rst_n (sync, active-low), en, dir, wrap_mode, step, lo, hi,
//   load, load_val -> count, at_hi, at_lo, sat_pulse, wrap_pulse, cfg_err.
module updown_bounded_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic              wrap_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              at_hi,
  output logic              at_lo,
  output logic              sat_pulse,
  output logic              wrap_pulse,
  output logic              cfg_err
);

  localparam int unsigned XW = WIDTH + 1;

  typedef logic [WIDTH-1:0] cnt_t;
  typedef logic [XW-1:0]    wide_t;

  // Bound checks run one bit wider so count+step or lo+step
  // can never wrap around and hide an overrun.
  wide_t cnt_x;
  wide_t step_x;
  wide_t lo_x;
  wide_t hi_x;
  wide_t sum_x;
  wide_t floor_x;

  logic over;
  logic under;
  logic clip;
  logic nonzero;

  cnt_t diff;
  cnt_t step_val;
  cnt_t clip_val;
  cnt_t load_clamped;

  logic sel_load;
  logic sel_step;

  cnt_t nxt_count;
  logic nxt_sat;
  logic nxt_wrap;

  assign cnt_x   = wide_t'(count);
  assign step_x  = wide_t'(step);
  assign lo_x    = wide_t'(lo);
  assign hi_x    = wide_t'(hi);
  assign sum_x   = cnt_x + step_x;
  assign floor_x = lo_x + step_x;

  assign over    = sum_x > hi_x;
  assign under   = cnt_x < floor_x;
  assign nonzero = |step;

  // Only used when no underrun, so count >= step and
  // the WIDTH-bit subtraction cannot borrow.
  assign diff = count - cnt_t'(step);

  assign clip     = dir ? over : under;
  assign step_val = dir ? sum_x[WIDTH-1:0] : diff;

  // Saturate clips to the bound crossed; wrap jumps
  // to the opposite bound with no residual carry.
  always_comb begin
    clip_val = lo;
    unique case (1'b1)
      dir && !wrap_mode:  clip_val = hi;
      dir && wrap_mode:   clip_val = lo;
      !dir && !wrap_mode: clip_val = lo;
      !dir && wrap_mode:  clip_val = hi;
      default:            clip_val = lo;
    endcase
  end

  always_comb begin
    load_clamped = load_val;
    if (load_val < lo) begin
      load_clamped = lo;
    end else if (load_val > hi) begin
      load_clamped = hi;
    end
  end

  assign cfg_err = lo > hi;
  assign at_hi   = count >= hi;
  assign at_lo   = count <= lo;

  // Mutually exclusive selects encode the
  // cfg_err > load > step > hold priority.
  assign sel_load = !cfg_err && load;
  assign sel_step = !cfg_err && !load && en && nonzero;

  always_comb begin
    nxt_count = count;
    nxt_sat   = 1'b0;
    nxt_wrap  = 1'b0;
    unique case (1'b1)
      sel_load: begin
        nxt_count = load_clamped;
      end
      sel_step && !clip: begin
        nxt_count = step_val;
      end
      sel_step && clip: begin
        nxt_count = clip_val;
        nxt_sat   = !wrap_mode;
        nxt_wrap  = wrap_mode;
      end
      default: begin
        nxt_count = count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= RST_VAL;
      sat_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= nxt_count;
      sat_pulse  <= nxt_sat;
      wrap_pulse <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_updown_bounded_counter.sv
// Directed bench for updown_bounded_counter (WIDTH=8, STEP_W=4).
// Hand-computed expectations checked with immediate assertions.
module tb_updown_bounded_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       wrap_mode;
  logic [3:0] step;
  logic [7:0] lo;
  logic [7:0] hi;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       at_hi;
  logic       at_lo;
  logic       sat_pulse;
  logic       wrap_pulse;
  logic       cfg_err;

  int checks;
  int errors;

  updown_bounded_counter #(
    .WIDTH(8),
    .STEP_W(4),
    .RST_VAL(8'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .dir(dir),
    .wrap_mode(wrap_mode),
    .step(step),
    .lo(lo),
    .hi(hi),
    .load(load),
    .load_val(load_val),
    .count(count),
    .at_hi(at_hi),
    .at_lo(at_lo),
    .sat_pulse(sat_pulse),
    .wrap_pulse(wrap_pulse),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input int c,
                      input int s,
                      input int w);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_sat"}, int'(sat_pulse), s);
    chk({tag, "_wrap"}, int'(wrap_pulse), w);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    dir       = 1'b1;
    wrap_mode = 1'b0;
    step      = 4'd3;
    lo        = 8'd10;
    hi        = 8'd200;
    load      = 1'b0;
    load_val  = 8'd0;

    // reset with en high
    tick();
    chk3("rst1", 0, 0, 0);
    tick();
    chk3("rst2", 0, 0, 0);
    rst_n = 1'b1;

    // saturate up from 195 by 3
    load     = 1'b1;
    load_val = 8'd195;
    tick();
    chk3("ld195", 195, 0, 0);
    load = 1'b0;
    tick();
    chk3("up198", 198, 0, 0);
    tick();
    chk3("sat200", 200, 1, 0);
    chk("sat_at_hi", int'(at_hi), 1);
    tick();
    chk3("sat200b", 200, 1, 0);
    en = 1'b0;
    tick();
    chk3("hold200", 200, 0, 0);

    // wrap down from 12 by 2
    wrap_mode = 1'b1;
    load      = 1'b1;
    load_val  = 8'd12;
    tick();
    chk3("ld12", 12, 0, 0);
    load = 1'b0;
    en   = 1'b1;
    dir  = 1'b0;
    step = 4'd2;
    tick();
    chk3("dn10", 10, 0, 0);
    chk("dn10_at_lo", int'(at_lo), 1);
    tick();
    chk3("wrap200", 200, 0, 1);
    en = 1'b0;
    tick();
    chk3("wrap_hold", 200, 0, 0);

    // load clamp wins over en
    wrap_mode = 1'b0;
    en        = 1'b1;
    dir       = 1'b1;
    load      = 1'b1;
    load_val  = 8'd250;
    tick();
    chk3("ldhi", 200, 0, 0);
    load_val = 8'd5;
    tick();
    chk3("ldlo", 10, 0, 0);

    // full-range width edge
    lo       = 8'd0;
    hi       = 8'd255;
    load_val = 8'd254;
    tick();
    chk3("ld254", 254, 0, 0);
    load = 1'b0;
    step = 4'd15;
    tick();
    chk3("sat255", 255, 1, 0);
    load     = 1'b1;
    load_val = 8'd3;
    tick();
    chk3("ld3", 3, 0, 0);
    load = 1'b0;
    dir  = 1'b0;
    tick();
    chk3("sat0", 0, 1, 0);

    // configuration error: everything ignored
    lo = 8'd50;
    hi = 8'd40;
    #1;
    chk("cfg_err_set", int'(cfg_err), 1);
    load     = 1'b1;
    load_val = 8'd45;
    tick();
    chk3("cfg_ld", 0, 0, 0);
    load = 1'b0;
    dir  = 1'b1;
    step = 4'd5;
    tick();
    chk3("cfg_en", 0, 0, 0);

    // lo == hi
    lo = 8'd40;
    #1;
    chk("cfg_err_clr", int'(cfg_err), 0);
    load     = 1'b1;
    load_val = 8'd40;
    tick();
    chk3("eq_ld", 40, 0, 0);
    load = 1'b0;
    tick();
    chk3("eq_sat", 40, 1, 0);
    wrap_mode = 1'b1;
    dir       = 1'b0;
    step      = 4'd3;
    tick();
    chk3("eq_wrap", 40, 0, 1);
    step = 4'd0;
    tick();
    chk3("eq_zero", 40, 0, 0);

    // count above hi, down step taken as-is
    lo        = 8'd10;
    hi        = 8'd20;
    wrap_mode = 1'b0;
    step      = 4'd5;
    tick();
    chk3("oor_dn", 35, 0, 0);
    chk("oor_at_hi", int'(at_hi), 1);
    dir = 1'b1;
    tick();
    chk3("oor_up", 20, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
